// File: rtl/nbit_serial_comparator.sv
// nbit_serial_comparator
//   Magnitude comparator for WIDTH-bit operands A and B, examined SLICE bits
//   per clock, most significant slice first. The compare stops at the first
//   slice that differs. Results Equal/Asmaller/Agreater are registered and
//   one-hot once a compare completes. Start/Busy/Done handshake.
//   Optional macro SIGNED_CMP_EN: treat operands as two's complement by
//   inverting the operand MSB on load (default build: unsigned operands).
module nbit_serial_comparator #(
    parameter int WIDTH = 4,
    parameter int SLICE = 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic             Equal,
    output logic             Asmaller,
    output logic             Agreater
);

    if (WIDTH < 1 || SLICE < 1 || SLICE > WIDTH || (WIDTH % SLICE) != 0) begin : g_param_chk
        $error("nbit_serial_comparator: need 1 <= SLICE <= WIDTH and WIDTH %% SLICE == 0");
    end

    localparam int N  = (SLICE > 0) ? (WIDTH / SLICE) : 1;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPARE,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic [KW-1:0]    k;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [SLICE-1:0] a_top;
    logic [SLICE-1:0] b_top;
    logic             last_slice;
    logic             slice_diff;

    // Flipping the sign bit maps two's complement order onto unsigned order,
    // so the slice-wise unsigned compare works unchanged for signed operands.
    function automatic logic [WIDTH-1:0] load_op(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] r;
        r = x;
`ifdef SIGNED_CMP_EN
        r[WIDTH-1] = ~x[WIDTH-1];
`endif
        return r;
    endfunction

    assign a_top      = a_sr[WIDTH-1 -: SLICE];
    assign b_top      = b_sr[WIDTH-1 -: SLICE];
    assign slice_diff = (a_top != b_top);
    assign last_slice = (k == KW'(N - 1));

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; a request is accepted only outside COMPARE
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (Start) begin
                    accept    = 1'b1;
                    state_nxt = S_COMPARE;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_COMPARE: begin
                if (slice_diff || last_slice) begin
                    state_nxt = S_DONE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Registered handshake, result bits and slice counter
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            Busy     <= 1'b0;
            Done     <= 1'b0;
            Equal    <= 1'b0;
            Asmaller <= 1'b0;
            Agreater <= 1'b0;
            k        <= '0;
        end else begin
            Done <= 1'b0;
            if (accept) begin
                Busy     <= 1'b1;
                Equal    <= 1'b0;
                Asmaller <= 1'b0;
                Agreater <= 1'b0;
                k        <= '0;
            end else if (state == S_COMPARE) begin
                if (slice_diff) begin
                    Agreater <= (a_top > b_top);
                    Asmaller <= (a_top < b_top);
                    Busy     <= 1'b0;
                    Done     <= 1'b1;
                end else if (last_slice) begin
                    Equal <= 1'b1;
                    Busy  <= 1'b0;
                    Done  <= 1'b1;
                end else begin
                    k <= k + KW'(1);
                end
            end
        end
    end

    // Operand shift registers: load on accept, move to next slice while comparing
    always_ff @(posedge CLK) begin
        if (accept) begin
            a_sr <= load_op(A);
            b_sr <= load_op(B);
        end else if (state == S_COMPARE) begin
            a_sr <= a_sr << SLICE;
            b_sr <= b_sr << SLICE;
        end
    end

endmodule
